// File: rtl/tm_pkg.sv
// Shared types and helpers for the Tsetlin-machine vote scheduler.
// Holds the FSM state encoding, the accumulator limits and the saturating add.
`timescale 1ns/1ps
package tm_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, SCAN, DONE} state_t;

  localparam int SUM_W_DEFAULT   = 8;
  localparam int SUM_MAX_DEFAULT = (1 << (SUM_W_DEFAULT - 1)) - 1;
  localparam int SUM_MIN_DEFAULT = -(1 << (SUM_W_DEFAULT - 1));

  function automatic int sum_max(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int sum_min(input int w);
    return -(1 << (w - 1));
  endfunction

  // Widened add clamped to [lo, hi]; both operands are already sign-extended.
  function automatic int sat_add(input int acc, input int delta, input int lo, input int hi);
    int s;
    s = acc + delta;
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

endpackage

// File: rtl/tm_beat_votes.sv
// Combinational vote delta of one beat: popcount(pos) - popcount(neg).
`timescale 1ns/1ps
module tm_beat_votes #(
  parameter int CL_W    = 2,
  parameter int DELTA_W = $clog2(CL_W) + 2
) (
  input  logic [CL_W-1:0]           pos,
  input  logic [CL_W-1:0]           neg,
  output logic signed [DELTA_W-1:0] delta
);

  int pos_cnt;
  int neg_cnt;

  always_comb begin
    pos_cnt = 0;
    neg_cnt = 0;
    for (int i = 0; i < CL_W; i++) begin
      pos_cnt = pos_cnt + int'(pos[i]);
      neg_cnt = neg_cnt + int'(neg[i]);
    end
    delta = DELTA_W'(pos_cnt - neg_cnt);
  end

endmodule

// File: rtl/tm_vote_scheduler.sv
// Streams clause beats into saturating per-class vote sums, then scans the
// classes one per cycle and presents the argmax on a valid/ready output.
`timescale 1ns/1ps
module tm_vote_scheduler
  import tm_pkg::*;
#(
  parameter int NUM_CLASSES = 2,
  parameter int CL_W        = 2,
  parameter int SUM_W       = SUM_W_DEFAULT,
  parameter int CLS_W       = (NUM_CLASSES > 2) ? $clog2(NUM_CLASSES) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  output logic                    busy,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [CLS_W-1:0]        in_class,
  input  logic [CL_W-1:0]         in_pos,
  input  logic [CL_W-1:0]         in_neg,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CLS_W-1:0]        out_class,
  output logic signed [SUM_W-1:0] out_votes
);

  localparam int DELTA_W = $clog2(CL_W) + 2;
  localparam int IDX_W   = $clog2(NUM_CLASSES + 1);
  localparam int SUM_MAX = sum_max(SUM_W);
  localparam int SUM_MIN = sum_min(SUM_W);

  state_t state;
  state_t next_state;

  logic signed [SUM_W-1:0]   sums [NUM_CLASSES];
  logic signed [DELTA_W-1:0] delta;
  logic signed [SUM_W-1:0]   scan_sum;
  logic signed [SUM_W-1:0]   best_sum;
  logic [CLS_W-1:0]          best_class;
  logic [IDX_W-1:0]          scan_idx;
  logic                      accept;
  logic                      scan_last;

  tm_beat_votes #(.CL_W(CL_W), .DELTA_W(DELTA_W)) u_beat_votes (
    .pos   (in_pos),
    .neg   (in_neg),
    .delta (delta)
  );

  assign in_ready  = (state == ACCUM);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign scan_last = (scan_idx == IDX_W'(NUM_CLASSES));
  assign scan_sum  = sums[CLS_W'(scan_idx)];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:  if (start) next_state = ACCUM;
      ACCUM: if (accept && in_last) next_state = SCAN;
      SCAN:  if (scan_last) next_state = DONE;
      DONE:  if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Out-of-range class beats are accepted but leave every sum untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CLASSES; i++) sums[i] <= '0;
    end else if (state == IDLE && start) begin
      for (int i = 0; i < NUM_CLASSES; i++) sums[i] <= '0;
    end else if (accept && int'(in_class) < NUM_CLASSES) begin
      sums[in_class] <= SUM_W'(sat_add(int'(sums[in_class]), int'(delta), SUM_MIN, SUM_MAX));
    end
  end

  // The extra cycle at scan_idx == NUM_CLASSES copies best into the output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_idx   <= '0;
      best_sum   <= '0;
      best_class <= '0;
      out_class  <= '0;
      out_votes  <= '0;
    end else begin
      case (state)
        SCAN: begin
          if (scan_last) begin
            out_class <= best_class;
            out_votes <= best_sum;
          end else begin
            if (scan_idx == '0 || scan_sum > best_sum) begin
              best_sum   <= scan_sum;
              best_class <= CLS_W'(scan_idx);
            end
            scan_idx <= scan_idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_class <= '0;
            out_votes <= '0;
          end
        end
        default: scan_idx <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_tm_vote_scheduler.sv
// Self-checking bench: two schedulers (SUM_W=8 and SUM_W=4) share one stimulus
// stream and are compared against a per-inference reference vote model.
`timescale 1ns/1ps
module tb_tm_vote_scheduler;

  typedef struct {
    int         cls;
    logic [1:0] pos;
    logic [1:0] neg;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       in_valid;
  logic       in_class;
  logic [1:0] in_pos;
  logic [1:0] in_neg;
  logic       in_last;
  logic       out_ready;

  logic        busy_a, in_ready_a, out_valid_a, out_class_a;
  logic [7:0]  out_votes_a;
  logic        busy_b, in_ready_b, out_valid_b, out_class_b;
  logic [3:0]  out_votes_b;

  int    checks = 0;
  int    fails  = 0;
  beat_t beatQ[$];

  always #5 clk = ~clk;

  tm_vote_scheduler #(.NUM_CLASSES(2), .CL_W(2), .SUM_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy_a),
    .in_valid(in_valid), .in_ready(in_ready_a), .in_class(in_class),
    .in_pos(in_pos), .in_neg(in_neg), .in_last(in_last),
    .out_valid(out_valid_a), .out_ready(out_ready),
    .out_class(out_class_a), .out_votes(out_votes_a)
  );

  tm_vote_scheduler #(.NUM_CLASSES(2), .CL_W(2), .SUM_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy_b),
    .in_valid(in_valid), .in_ready(in_ready_b), .in_class(in_class),
    .in_pos(in_pos), .in_neg(in_neg), .in_last(in_last),
    .out_valid(out_valid_b), .out_ready(out_ready),
    .out_class(out_class_b), .out_votes(out_votes_b)
  );

  task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                             input logic signed [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  function automatic int popcnt(input logic [1:0] v);
    return int'(v[0]) + int'(v[1]);
  endfunction

  function automatic int clampW(input int v, input int w);
    int hi, lo;
    hi = 2 ** (w - 1) - 1;
    lo = -(2 ** (w - 1));
    return (v > hi) ? hi : ((v < lo) ? lo : v);
  endfunction

  // Reference: accumulate every queued beat with clamping, then argmax, ties to lowest class.
  task automatic computeModel(input int w, output int expClass, output int expVotes);
    int s[2];
    s[0] = 0;
    s[1] = 0;
    foreach (beatQ[i])
      if (beatQ[i].cls < 2)
        s[beatQ[i].cls] = clampW(s[beatQ[i].cls] + popcnt(beatQ[i].pos) - popcnt(beatQ[i].neg), w);
    expClass = 0;
    expVotes = s[0];
    if (s[1] > s[0]) begin
      expClass = 1;
      expVotes = s[1];
    end
  endtask

  task automatic pulseStart();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic applyStimulus(input beat_t b, input logic last);
    int waited;
    @(negedge clk);
    in_valid = 1'b1;
    in_class = 1'(b.cls);
    in_pos   = b.pos;
    in_neg   = b.neg;
    in_last  = last;
    waited   = 0;
    while (!in_ready_a && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 20) checkOutput("beat_ready_timeout", 0, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic consumeResult(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    checkOutput({tag, "_busy_after"}, busy_a, 0);
    checkOutput({tag, "_valid_after"}, out_valid_a, 0);
    checkOutput({tag, "_class_after"}, out_class_a, 0);
    checkOutput({tag, "_votes_after"}, $signed(out_votes_a), 0);
  endtask

  // Runs the queued beats as one inference and checks latency and both results.
  task automatic runAndCheck(input string tag, input bit consume);
    int edges, ca, va, cb, vb;
    pulseStart();
    foreach (beatQ[i]) applyStimulus(beatQ[i], (i == beatQ.size() - 1));
    edges = 0;
    while (!out_valid_a && edges < 20) begin
      @(posedge clk);
      #1 edges++;
    end
    computeModel(8, ca, va);
    computeModel(4, cb, vb);
    checkOutput({tag, "_latency"}, edges, 3);
    checkOutput({tag, "_valid_b"}, out_valid_b, 1);
    checkOutput({tag, "_class_a"}, out_class_a, ca);
    checkOutput({tag, "_votes_a"}, $signed(out_votes_a), va);
    checkOutput({tag, "_class_b"}, out_class_b, cb);
    checkOutput({tag, "_votes_b"}, $signed(out_votes_b), vb);
    if (consume) consumeResult(tag);
  endtask

  function automatic beat_t mk(input int cls, input logic [1:0] pos, input logic [1:0] neg);
    beat_t b;
    b.cls = cls;
    b.pos = pos;
    b.neg = neg;
    return b;
  endfunction

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int hc, hv;
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_class = 1'b0;
    in_pos = '0; in_neg = '0; in_last = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", busy_a, 0);
    checkOutput("reset_in_ready", in_ready_a, 0);
    checkOutput("reset_out_valid", out_valid_a, 0);
    checkOutput("reset_out_class", out_class_a, 0);
    checkOutput("reset_out_votes", $signed(out_votes_a), 0);
    rst_n = 1'b1;

    // A beat offered while idle must not be accepted.
    @(negedge clk);
    in_valid = 1'b1;
    in_pos = 2'b11;
    @(negedge clk);
    checkOutput("idle_in_ready", in_ready_a, 0);
    checkOutput("idle_busy", busy_a, 0);
    in_valid = 1'b0;
    in_pos = 2'b00;

    beatQ = '{mk(0, 2'b11, 2'b00), mk(1, 2'b01, 2'b01)};
    runAndCheck("defaults", 1'b1);
    beatQ = '{mk(0, 2'b01, 2'b01), mk(1, 2'b10, 2'b10)};
    runAndCheck("tie", 1'b1);
    beatQ = '{mk(0, 2'b00, 2'b11), mk(1, 2'b10, 2'b00)};
    runAndCheck("class1_wins", 1'b1);

    beatQ.delete();
    repeat (5) beatQ.push_back(mk(0, 2'b11, 2'b00));
    beatQ.push_back(mk(1, 2'b00, 2'b00));
    runAndCheck("sat_pos", 1'b1);
    beatQ.delete();
    repeat (5) beatQ.push_back(mk(0, 2'b00, 2'b11));
    beatQ.push_back(mk(1, 2'b00, 2'b00));
    runAndCheck("sat_neg", 1'b1);

    // Backpressure with a stray start while the result is held.
    beatQ = '{mk(1, 2'b11, 2'b01), mk(0, 2'b01, 2'b00)};
    runAndCheck("bp", 1'b0);
    computeModel(8, hc, hv);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start = (i == 2);
      @(posedge clk);
      #1 start = 1'b0;
      checkOutput("bp_hold_valid", out_valid_a, 1);
      checkOutput("bp_hold_class", out_class_a, hc);
      checkOutput("bp_hold_votes", $signed(out_votes_a), hv);
    end
    consumeResult("bp");
    @(negedge clk);
    checkOutput("bp_stays_idle", busy_a, 0);

    // Reset in the middle of accumulation.
    pulseStart();
    applyStimulus(mk(1, 2'b11, 2'b00), 1'b0);
    applyStimulus(mk(1, 2'b11, 2'b00), 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_busy", busy_a, 0);
    checkOutput("midreset_in_ready", in_ready_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    beatQ = '{mk(0, 2'b01, 2'b00)};
    runAndCheck("after_reset", 1'b1);

    for (int r = 0; r < 30; r++) begin
      int n;
      n = $urandom_range(1, 8);
      beatQ.delete();
      for (int k = 0; k < n; k++)
        beatQ.push_back(mk($urandom_range(0, 1), 2'($urandom), 2'($urandom)));
      runAndCheck("random", 1'b0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      checkOutput("random_held", out_valid_a, 1);
      consumeResult("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/tm_vote_scheduler.md
Name: tm_vote_scheduler

Overview:
- Sequential class-vote accumulator and argmax controller for the Tsetlin-machine inference datapath.
- Clause outputs arrive as a stream of beats over a valid/ready handshake; each beat carries positive- and negative-polarity clause bits for one class.
- The block accumulates signed votes per class, scans the classes for the winner, and presents the class index and its vote total on an output handshake.
- Replaces the fixed two-class combinational compare with a scalable, pipelined one.

Parameters:
- NUM_CLASSES, 2: number of classes, ≥2.
- CL_W, 2: clause bits per polarity per beat.
- SUM_W, 8: signed vote accumulator width.
- CLS_W, $clog2(NUM_CLASSES) (min 1): class index width, derived.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins an inference when idle.
- busy  out  1  high whenever state != IDLE.
- in_valid  in  1  beat valid.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- in_class  in  CLS_W  target class of the beat.
- in_pos  in  CL_W  positive-polarity clause outputs.
- in_neg  in  CL_W  negative-polarity clause outputs.
- in_last  in  1  final beat of the inference.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed when out_valid && out_ready.
- out_class  out  CLS_W  winning class.
- out_votes  out  SUM_W  signed vote total of the winning class.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all sums, scan index and best registers cleared. Outputs busy=0, in_ready=0, out_valid=0, out_class=0, out_votes=0.
- FSM states: IDLE, ACCUM, SCAN, DONE.
- IDLE:
  - in_ready=0.
  - start=1 → clear all NUM_CLASSES sums; next state ACCUM.
- ACCUM:
  - in_ready=1 combinationally (state-decoded, no dependence on in_valid).
  - On each accepted beat: sum[in_class] += popcount(in_pos) − popcount(in_neg).
  - The addition saturates to [−2^(SUM_W−1), 2^(SUM_W−1)−1].
  - A beat with in_class ≥ NUM_CLASSES is accepted and discarded; in_last on it still applies.
  - Accepted beat with in_last=1 → SCAN. Its contribution is included in the sums.
- SCAN:
  - One class per cycle, index 0..NUM_CLASSES−1.
  - Index 0 loads best. For later indices, best is replaced only if sum[idx] > best_sum (strict), so ties go to the lowest index.
  - After index NUM_CLASSES−1 is evaluated → DONE.
- DONE:
  - out_valid=1, with out_class and out_votes registered and stable until handshake.
  - out_ready=1 → IDLE next cycle. out_valid drops and outputs return to 0.
- Latency: out_valid rises NUM_CLASSES+1 clock edges after the in_last handshake edge.
- start while busy: ignored, with no effect on sums or state.
- in_valid while not in ACCUM: not accepted, because in_ready=0.
- Zero-beat inference is not possible: at least one beat, carrying in_last, is required.
- Reset mid-operation: immediate return to IDLE. No partial result is emitted, and the next start clears the sums again.

Decomposition:
- Package tm_pkg holds:
  - state enum {IDLE, ACCUM, SCAN, DONE};
  - saturating signed add function;
  - localparams for the SUM_W min/max limits.
- One sub-module: tm_beat_votes, combinational. It takes in_pos and in_neg and outputs a signed delta of width $clog2(CL_W)+2 (popcount difference).

Test Plan:
1. Defaults. start; beat cls0 pos=11 neg=00; beat cls1 pos=01 neg=01 last → out_class=0, out_votes=+2, out_valid 3 edges after last.
2. Tie. cls0 pos=01 neg=01; cls1 pos=10 neg=10 last → out_class=0, out_votes=0.
3. Class 1 wins. cls0 pos=00 neg=11 (−2); cls1 pos=10 neg=00 last (+1) → out_class=1, out_votes=+1.
4. Saturation, SUM_W=4. Five cls0 beats pos=11 neg=00, plus a cls1 beat with pos=00 neg=00 → out_votes=+7, not 10, out_class=0. Repeat with neg=11 → cls0 sum=−8, out_class=1, out_votes=0.
5. Backpressure. out_ready=0 for 5 cycles in DONE, start pulsed meanwhile → out_valid, out_class and out_votes held, start ignored. out_ready=1 → IDLE next cycle, busy=0.
6. Reset mid-ACCUM after two cls1 +2 beats → busy=0, in_ready=0 immediately. New run with a single cls0 beat pos=01 last → out_class=0, out_votes=+1 (old sums not retained).
